gpr_wb_sched: RTL and testbench

Writeback scheduler for the 32x32-bit general-purpose register file (two synchronous write ports, A and B). It arbitrates up to NREQ writeback requesters (ALU, load unit, multi-cycle units) onto the two write ports, granting up to two non-conflicting writes per cycle with round-robin fairness. After reset it sequences a zero-fill of all 32 registers before accepting any request. It sits between the execute/memory writeback paths and the register file write ports.

---
 rtl/gpr_wb_sched_pkg.sv | 31 +++
 rtl/gpr_wb_rr_pick.sv | 33 +++
 rtl/gpr_wb_sched.sv | 191 +++++++++++++++++++
 tb/tb_gpr_wb_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_sched_pkg.sv
// Shared register-file geometry, scheduler state encoding and write-port record.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gpr_wb_sched_pkg;

    localparam int GPR_COUNT  = 32;
    localparam int GPR_SEL_W  = 5;
    localparam int GPR_W      = 32;

    // Zero-fill writes two registers per cycle.
    localparam int FILL_STEPS = GPR_COUNT / 2;
    localparam int FILL_W     = $clog2(FILL_STEPS);

    typedef enum logic {
        WBS_INIT = 1'b0,
        WBS_RUN  = 1'b1
    } wbs_state_e;

    typedef struct packed {
        logic                 en;
        logic [GPR_SEL_W-1:0] sel;
        logic [GPR_W-1:0]     val;
    } wr_port_t;

    // Register written by a fill step: even one on port A, odd one on port B.
    function automatic logic [GPR_SEL_W-1:0] fill_sel(input logic [FILL_W-1:0] step,
                                                      input logic              odd);
        return {step, odd};
    endfunction

endpackage

// File: rtl/gpr_wb_rr_pick.sv
// Rotate-priority picker: first valid, unmasked index at or after start, modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; caller decides what to do with the pick.
module gpr_wb_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the requesters once, beginning at start and wrapping; keep the first hit.
    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = 0; off < NREQ; off++) begin
            pos = int'(start) + off;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && valid[pos] && !mask[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/gpr_wb_sched.sv
// Writeback scheduler: zero-fills the GPR file after reset, then grants up to two
// non-conflicting requesters per cycle (round-robin) onto write ports A and B.
// Latency: accept in cycle N -> port outputs registered at end of N, write lands end of N+1.
// Backpressure: req_ready is combinational from req_valid; deferred requesters hold and retry.
module gpr_wb_sched
    import gpr_wb_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [GPR_SEL_W*NREQ-1:0] req_reg,
    input  logic [GPR_W*NREQ-1:0]     req_val,
    output logic [NREQ-1:0]           req_ready,
    output logic                      write_a_en,
    output logic [GPR_SEL_W-1:0]      write_a_select,
    output logic [GPR_W-1:0]          write_a_val,
    output logic                      write_b_en,
    output logic [GPR_SEL_W-1:0]      write_b_select,
    output logic [GPR_W-1:0]          write_b_val,
    output logic                      init_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    wbs_state_e           state_q;
    wbs_state_e           state_d;
    logic [FILL_W-1:0]    fill_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     rr_next;
    logic [IDX_W-1:0]     last_idx;

    wr_port_t             port_a_q;
    wr_port_t             port_b_q;
    wr_port_t             port_a_d;
    wr_port_t             port_b_d;

    logic                 g0_found;
    logic [IDX_W-1:0]     g0_idx;
    logic                 g1_found;
    logic [IDX_W-1:0]     g1_idx;
    logic [GPR_SEL_W-1:0] g0_reg;
    logic [GPR_W-1:0]     g0_val;
    logic [GPR_SEL_W-1:0] g1_reg;
    logic [GPR_W-1:0]     g1_val;
    logic [NREQ-1:0]      mask0;
    logic [NREQ-1:0]      mask1;

    // ------------------------------------------------------------------
    // Arbitration: G0 is the first valid requester from rr_ptr; G1 is the
    // next one that targets a different register than G0.
    // ------------------------------------------------------------------
    assign mask0 = '0;

    gpr_wb_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_g0 (
        .valid (req_valid),
        .mask  (mask0),
        .start (rr_ptr_q),
        .found (g0_found),
        .idx   (g0_idx)
    );

    assign g0_reg = req_reg[int'(g0_idx)*GPR_SEL_W +: GPR_SEL_W];
    assign g0_val = req_val[int'(g0_idx)*GPR_W +: GPR_W];

    // Exclude G0 itself and anyone writing G0's register, so one register never hits both ports.
    always_comb begin
        mask1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask1[i] = (IDX_W'(i) == g0_idx) ||
                       (req_reg[i*GPR_SEL_W +: GPR_SEL_W] == g0_reg);
        end
    end

    gpr_wb_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_g1 (
        .valid (req_valid),
        .mask  (mask1),
        .start (rr_ptr_q),
        .found (g1_found),
        .idx   (g1_idx)
    );

    assign g1_reg = req_reg[int'(g1_idx)*GPR_SEL_W +: GPR_SEL_W];
    assign g1_val = req_val[int'(g1_idx)*GPR_W +: GPR_W];

    // Pointer moves just past the last requester granted this cycle.
    always_comb begin
        last_idx = g1_found ? g1_idx : g0_idx;
        rr_next  = (last_idx == IDX_W'(NREQ - 1)) ? '0 : last_idx + IDX_W'(1);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WBS_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT once the last fill pair has been presented.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WBS_INIT: if (fill_q == FILL_W'(FILL_STEPS - 1)) state_d = WBS_RUN;
            WBS_RUN:  state_d = WBS_RUN;
            default:  state_d = WBS_INIT;
        endcase
    end

    // Outputs: fill pair in INIT, granted requesters in RUN; idle ports keep select/val.
    always_comb begin
        port_a_d    = port_a_q;
        port_b_d    = port_b_q;
        port_a_d.en = 1'b0;
        port_b_d.en = 1'b0;
        req_ready   = '0;
        case (state_q)
            WBS_INIT: begin
                port_a_d.en  = 1'b1;
                port_a_d.sel = fill_sel(fill_q, 1'b0);
                port_a_d.val = '0;
                port_b_d.en  = 1'b1;
                port_b_d.sel = fill_sel(fill_q, 1'b1);
                port_b_d.val = '0;
            end
            WBS_RUN: begin
                if (g0_found) begin
                    port_a_d.en       = 1'b1;
                    port_a_d.sel      = g0_reg;
                    port_a_d.val      = g0_val;
                    req_ready[g0_idx] = 1'b1;
                end
                if (g1_found) begin
                    port_b_d.en       = 1'b1;
                    port_b_d.sel      = g1_reg;
                    port_b_d.val      = g1_val;
                    req_ready[g1_idx] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Fill step counter; wraps to zero as INIT finishes and stays there in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= '0;
        end else if (state_q == WBS_INIT) begin
            fill_q <= fill_q + FILL_W'(1);
        end
    end

    // Round-robin pointer; only advances when something was granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (state_q == WBS_RUN && g0_found) begin
            rr_ptr_q <= rr_next;
        end
    end

    // Registered write ports; reset drops any in-flight write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_a_q <= '0;
            port_b_q <= '0;
        end else begin
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
        end
    end

    assign write_a_en     = port_a_q.en;
    assign write_a_select = port_a_q.sel;
    assign write_a_val    = port_a_q.val;
    assign write_b_en     = port_b_q.en;
    assign write_b_select = port_b_q.sel;
    assign write_b_val    = port_b_q.val;
    assign init_done      = (state_q == WBS_RUN);

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched with a behavioural register-file model.
// Latency: inputs driven after the rising edge, outputs sampled on the falling edge.
// Backpressure: requesters hold valid until their ready is seen.
module tb_gpr_wb_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_reg;
    logic [32*NREQ-1:0] req_val;
    logic [NREQ-1:0]   req_ready;
    logic              write_a_en;
    logic [4:0]        write_a_select;
    logic [31:0]       write_a_val;
    logic              write_b_en;
    logic [4:0]        write_b_select;
    logic [31:0]       write_b_val;
    logic              init_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [32] = '{default: 32'hDEADBEEF};

    gpr_wb_sched #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_reg        (req_reg),
        .req_val        (req_val),
        .req_ready      (req_ready),
        .write_a_en     (write_a_en),
        .write_a_select (write_a_select),
        .write_a_val    (write_a_val),
        .write_b_en     (write_b_en),
        .write_b_select (write_b_select),
        .write_b_val    (write_b_val),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    // Register file: synchronous writes, B applied after A.
    always @(posedge clk) begin
        if (write_a_en) rf[write_a_select] <= write_a_val;
        if (write_b_en) rf[write_b_select] <= write_b_val;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] v);
        req_reg[i*5 +: 5]   = r;
        req_val[i*32 +: 32] = v;
    endtask

    // Sixteen paired zero writes, ready held low even with every requester valid.
    task automatic check_fill();
        int nz;
        req_valid = 4'hF;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("fill_a", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'(2*k), 32'h0});
            chk("fill_b", {write_b_en, write_b_select, write_b_val}, {1'b1, 5'(2*k+1), 32'h0});
            chk("fill_done", init_done, (k == 15));
            if (k < 14) chk("fill_ready", req_ready, 4'h0);
            if (k == 13) req_valid = 4'h0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_fill_en", {write_a_en, write_b_en}, 2'b00);
        chk("post_fill_ready", req_ready, 4'h0);
        nz = 0;
        for (int r = 0; r < 32; r++) if (rf[r] !== 32'h0) nz++;
        chk("rf_all_zero", nz, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_reg   = '0;
        req_val   = '0;

        // Reset state
        #12;
        chk("rst_a", {write_a_en, write_a_select, write_a_val}, 38'h0);
        chk("rst_b", {write_b_en, write_b_select, write_b_val}, 38'h0);
        chk("rst_done_ready", {init_done, req_ready}, 5'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        check_fill();

        // Two independent requesters, rr_ptr 0
        set_req(0, 5'd3, 32'h11);
        set_req(2, 5'd7, 32'h22);
        req_valid = 4'b0101;
        #1 chk("pair_ready", req_ready, 4'b0101);
        @(posedge clk);
        #1 req_valid = 4'h0;
        @(negedge clk);
        chk("pair_a", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'd3, 32'h11});
        chk("pair_b", {write_b_en, write_b_select, write_b_val}, {1'b1, 5'd7, 32'h22});

        // rr_ptr now 3: requester 3 goes first onto port A
        set_req(0, 5'd9, 32'h33);
        set_req(3, 5'd10, 32'h44);
        req_valid = 4'b1001;
        #1 chk("rr3_ready", req_ready, 4'b1001);
        @(posedge clk);
        #1 req_valid = 4'h0;
        @(negedge clk);
        chk("rr3_a", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'd10, 32'h44});
        chk("rr3_b", {write_b_en, write_b_select, write_b_val}, {1'b1, 5'd9, 32'h33});
        chk("rf3", rf[3], 32'h11);
        chk("rf7", rf[7], 32'h22);

        // Same-register conflict: req 1 first, req 2 deferred one cycle
        set_req(1, 5'd5, 32'hA);
        set_req(2, 5'd5, 32'hB);
        req_valid = 4'b0110;
        #1 chk("conf_ready0", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = 4'b0100;
        @(negedge clk);
        chk("conf_a0", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'd5, 32'hA});
        chk("conf_b0_en", write_b_en, 1'b0);
        chk("conf_ready1", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid = 4'h0;
        @(negedge clk);
        chk("conf_a1", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'd5, 32'hB});
        chk("conf_b1_en", write_b_en, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rf5_last", rf[5], 32'hB);
        chk("rf9", rf[9], 32'h33);
        chk("rf10", rf[10], 32'h44);

        // rr_ptr 3: lone requester 3 brings the pointer back to 0
        set_req(3, 5'd11, 32'h55);
        req_valid = 4'b1000;
        #1 chk("wrap_ready", req_ready, 4'b1000);
        @(posedge clk);
        #1 req_valid = 4'h0;

        // All four valid, distinct registers: (0,1),(2,3),(0,1),...
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 5'(20 + i), 32'h100 + i);
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1 chk("all_ready", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            if (c > 0)
                chk("all_sel", {write_a_select, write_b_select},
                    (c % 2 == 1) ? {5'd20, 5'd21} : {5'd22, 5'd23});
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 4'h0;
        chk("all_last_a", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'd20, 32'h100});
        chk("all_last_b", {write_b_en, write_b_select, write_b_val}, {1'b1, 5'd21, 32'h101});

        // Idle: enables drop, selects hold, pointer stays at 2
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_en", {write_a_en, write_b_en}, 2'b00);
            chk("idle_ready", req_ready, 4'h0);
        end
        chk("idle_hold_sel", {write_a_select, write_b_select}, {5'd20, 5'd21});
        set_req(0, 5'd24, 32'h66);
        set_req(2, 5'd25, 32'h77);
        req_valid = 4'b0101;
        #1 chk("idle_ptr_ready", req_ready, 4'b0101);
        @(posedge clk);
        #1 req_valid = 4'h0;
        @(negedge clk);
        chk("idle_ptr_a", {write_a_en, write_a_select, write_a_val}, {1'b1, 5'd25, 32'h77});
        chk("idle_ptr_b", {write_b_en, write_b_select, write_b_val}, {1'b1, 5'd24, 32'h66});

        // Reset while a write sits in the port registers
        set_req(1, 5'd30, 32'h5555);
        req_valid = 4'b0010;
        @(posedge clk);
        #1 req_valid = 4'h0;
        chk("inflight_a", {write_a_en, write_a_select}, {1'b1, 5'd30});
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_en", {write_a_en, write_b_en}, 2'b00);
        chk("mid_rst_done", init_done, 1'b0);
        chk("mid_rst_ready", req_ready, 4'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rf30_dropped", rf[30], 32'h0);
        chk("rf25", rf[25], 32'h77);
        @(posedge clk);
        #1 reset = 1'b1;
        check_fill();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
